data_memory_lsu: RTL

Load/store unit: the initiator (master) side of DataMemoryBus, placed between the core's memory stage and the data memory slave.
- Accepts byte, half and word load/store requests through a valid/ready handshake.
- Generates the aligned word address, byte write mask and lane-shifted write data.
- Extracts and sign- or zero-extends load data.
- Splits accesses that cross a word boundary into two bus accesses.

---
 rtl/data_memory_lsu_pkg.sv | 28 ++
 rtl/data_memory_lsu_align.sv | 24 ++
 rtl/data_memory_lsu.sv | 134 +++++++++++++
 3 files changed

// File: rtl/data_memory_lsu_pkg.sv
// data_memory_lsu_pkg: shared types and size helpers for the load/store unit
package data_memory_lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } AccessSize;

    typedef logic [3:0] ByteMask;

    typedef enum logic [2:0] {
        IDLE,
        ONE,
        LO,
        HI,
        FAULT
    } LsuState;

    function automatic ByteMask base_mask(input logic [1:0] size);
        return size == SIZE_WORD ? 4'b1111 : size == SIZE_HALF ? 4'b0011 : 4'b0001;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SIZE_WORD ? 3'd4 : size == SIZE_HALF ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/data_memory_lsu_align.sv
// data_memory_lsu_align: byte-lane mask, store-data lane shift and load-data extension
module data_memory_lsu_align
    import data_memory_lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output ByteMask     mask,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_ext
);

    assign mask     = base_mask(size) << offset;
    assign wr_lanes = wr_data << {offset, 3'b000};

    always_comb begin
        rd_ext = size == SIZE_WORD ? rd_data :
                 size == SIZE_HALF ? {{16{~zero_ext & rd_data[15]}}, rd_data[15:0]} :
                                     {{24{~zero_ext & rd_data[7]}}, rd_data[7:0]};
    end

endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: DataMemoryBus initiator with range check and word-crossing split
// Build option LSU_MISALIGNED_EN: split word-crossing accesses via LO/HI instead of faulting them.
module data_memory_lsu
    import data_memory_lsu_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0,
    parameter int unsigned SIZE = 1024
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_write,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wrData,
    output logic        o_done,
    output logic [31:0] o_rdData,
    output logic        o_fault,
    output logic [31:0] bus_addr,
    output logic        bus_wrEnable,
    output ByteMask     bus_wrMask,
    output logic [31:0] bus_wrData,
    input  logic [31:0] bus_rdData
);

    LsuState     state, state_n;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_data;
    logic [32:0] rel_addr;
    logic        accept, bad, crosses, done_n;
    logic [1:0]  off;
    logic [2:0]  rem;
    logic [31:0] word_addr, ld_word, al_wr, rd_ext;
    ByteMask     al_mask;

    assign o_ready   = state == IDLE;
    assign accept    = i_valid && o_ready;
    // 33-bit relative address: bit 32 flags below BASE, and the end check cannot wrap
    assign rel_addr  = {1'b0, i_addr} - {1'b0, BASE};
    assign bad       = i_size == 2'b11 || rel_addr[32] || rel_addr + 33'(size_bytes(i_size)) > 33'(SIZE);
    assign crosses   = ({1'b0, i_addr[1:0]} + size_bytes(i_size)) > 3'd4;
    assign off       = req_addr[1:0];
    assign rem       = 3'd4 - {1'b0, off};
    assign word_addr = {req_addr[31:2], 2'b00};
    assign done_n    = state == ONE || state == HI || state == FAULT;

`ifdef LSU_MISALIGNED_EN
    logic [31:0] lo_data;

    always_ff @(posedge i_clock) begin
        if (state == LO) lo_data <= bus_rdData >> {off, 3'b000};
    end

    assign ld_word = state == HI ? (lo_data | (bus_rdData << {rem, 3'b000})) : bus_rdData >> {off, 3'b000};
`else
    assign ld_word = bus_rdData >> {off, 3'b000};
`endif

    data_memory_lsu_align u_align (
        .offset   (off),
        .size     (req_size),
        .zero_ext (req_unsigned),
        .wr_data  (req_data),
        .rd_data  (ld_word),
        .mask     (al_mask),
        .wr_lanes (al_wr),
        .rd_ext   (rd_ext)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge i_clock) begin
        if (accept) begin
            req_write    <= i_write;
            req_size     <= i_size;
            req_unsigned <= i_unsigned;
            req_addr     <= i_addr;
            req_data     <= i_wrData;
        end
    end

    always_comb begin
        state_n      = state;
        bus_addr     = '0;
        bus_wrEnable = 1'b0;
        bus_wrMask   = '0;
        bus_wrData   = '0;
        case (state)
            IDLE: begin
`ifdef LSU_MISALIGNED_EN
                if (accept) state_n = bad ? FAULT : crosses ? LO : ONE;
`else
                if (accept) state_n = (bad || crosses) ? FAULT : ONE;
`endif
            end
            ONE, LO: begin
                bus_addr     = word_addr;
                bus_wrEnable = req_write;
                bus_wrMask   = al_mask;
                bus_wrData   = al_wr;
                state_n      = state == LO ? HI : IDLE;
            end
`ifdef LSU_MISALIGNED_EN
            HI: begin
                bus_addr     = word_addr + 32'd4;
                bus_wrEnable = req_write;
                bus_wrMask   = base_mask(req_size) >> rem;
                bus_wrData   = req_data >> {rem, 3'b000};
                state_n      = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_done   <= 1'b0;
            o_fault  <= 1'b0;
            o_rdData <= '0;
        end else begin
            o_done  <= done_n;
            o_fault <= state == FAULT;
            if (done_n) o_rdData <= (state == FAULT || req_write) ? 32'h0 : rd_ext;
        end
    end

endmodule
